// File: rtl/adpll_pi_filter_gs_pkg.sv
// -----------------------------------------------------------------------------
// adpll_pkg
// Shared definitions for the gear-shifting ADPLL PI loop filter: the loop
// state enum and the numeric encodings presented on the filter's mode output.
// -----------------------------------------------------------------------------
package adpll_pkg;

  localparam logic [1:0] MODE_ACQ   = 2'd0;
  localparam logic [1:0] MODE_TRACK = 2'd1;
  localparam logic [1:0] MODE_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    ST_ACQ   = MODE_ACQ,
    ST_TRACK = MODE_TRACK,
    ST_HOLD  = MODE_HOLD
  } state_t;

endpackage : adpll_pkg

// File: rtl/adpll_pi_filter_gs_if.sv
// -----------------------------------------------------------------------------
// adpll_pi_filter_gs_if
// Bundles the PFD decision strobe, gain/threshold configuration and the
// filter's control-word outputs.
//   master : drives pd_valid/early/freeze, gains, thresholds; reads results
//   slave  : the loop filter itself
// Outputs: dco_word (signed W), int_word (signed W+FRAC), int_sat, out_sat,
//          locked, mode (0 ACQ, 1 TRACK, 2 HOLD).
// -----------------------------------------------------------------------------
interface adpll_pi_filter_gs_if #(
  parameter int W    = 8,
  parameter int FRAC = 4,
  parameter int SW   = 6,
  parameter int CW   = 6
);
  localparam int IW = W + FRAC;

  logic                 pd_valid;
  logic                 early;
  logic                 freeze;
  logic [SW-1:0]        ki_acq;
  logic [SW-1:0]        ki_trk;
  logic [SW-1:0]        kp_acq;
  logic [SW-1:0]        kp_trk;
  logic [SW-1:0]        kp_boost;
  logic [CW-1:0]        lock_thr;
  logic [CW-1:0]        unlock_thr;
  logic signed [W-1:0]  dco_word;
  logic signed [IW-1:0] int_word;
  logic                 int_sat;
  logic                 out_sat;
  logic                 locked;
  logic [1:0]           mode;

  modport master (
    output pd_valid, early, freeze, ki_acq, ki_trk, kp_acq, kp_trk, kp_boost,
           lock_thr, unlock_thr,
    input  dco_word, int_word, int_sat, out_sat, locked, mode
  );

  modport slave (
    input  pd_valid, early, freeze, ki_acq, ki_trk, kp_acq, kp_trk, kp_boost,
           lock_thr, unlock_thr,
    output dco_word, int_word, int_sat, out_sat, locked, mode
  );

endinterface : adpll_pi_filter_gs_if

// File: rtl/adpll_pi_filter_gs_sat_add.sv
// -----------------------------------------------------------------------------
// sat_add
// Signed add of two IN_W operands in IN_W+1 bits, clamped to the signed
// OUT_W range (OUT_W <= IN_W).
//   a_i, b_i : signed operands
//   sum_o    : clamped sum
//   sat_o    : high when the clamp was applied
// -----------------------------------------------------------------------------
module sat_add #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  b_i,
  output logic signed [OUT_W-1:0] sum_o,
  output logic                    sat_o
);

  // Limits of the OUT_W range, sign-extended to the full sum width.
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] sum_full;

  assign sum_full = {a_i[IN_W-1], a_i} + {b_i[IN_W-1], b_i};

  // NOTE: every output gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sum_o = sum_full[OUT_W-1:0];
    sat_o = 1'b0;
    if (sum_full > MAX_V) begin
      sum_o = MAX_V[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (sum_full < MIN_V) begin
      sum_o = MIN_V[OUT_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule : sat_add

// File: rtl/adpll_pi_filter_gs.sv
// -----------------------------------------------------------------------------
// adpll_pi_filter_gs
// Gear-shifting PI loop filter: turns bang-bang early/late decisions into a
// signed DCO control word. Saturating integrator, proportional path with a
// boost on decision reversals, and an ACQ/TRACK/HOLD state machine that
// selects the gain set.
//   clk, reset : clock, synchronous active-high reset
//   bus        : adpll_pi_filter_gs_if slave (decisions, gains, results)
// -----------------------------------------------------------------------------
module adpll_pi_filter_gs
  import adpll_pkg::*;
#(
  parameter int W    = 8,
  parameter int FRAC = 4,
  parameter int SW   = 6,
  parameter int CW   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  adpll_pi_filter_gs_if.slave  bus
);

  localparam int IW = W + FRAC;
  localparam int OW = W + 1;  // output adder operand width (sum is W+2 bits)

  state_t               state_q, state_d;
  logic signed [IW-1:0] int_q, int_d;
  logic signed [W-1:0]  dco_q, dco_d;
  logic                 int_sat_q, int_sat_d;
  logic                 out_sat_q, out_sat_d;
  logic [CW-1:0]        rev_cnt_q, rev_cnt_d;
  logic [CW-1:0]        same_cnt_q, same_cnt_d;
  logic                 prev_early_q, prev_early_d;
  logic                 have_prev_q, have_prev_d;

  // ---------------- datapath ----------------
  logic                 is_acq, reversal;
  logic [SW-1:0]        ki_sel, kp_sel;
  logic signed [IW-1:0] ki_ext, ki_s, int_next;
  logic [SW:0]          prop_mag;
  logic signed [OW-1:0] prop_ext, prop_s, int_shr;
  logic signed [W-1:0]  dco_next, dco_hold;
  logic                 int_clamp, out_clamp;

  assign is_acq   = (state_q == ST_ACQ);
  assign ki_sel   = is_acq ? bus.ki_acq : bus.ki_trk;
  assign kp_sel   = is_acq ? bus.kp_acq : bus.kp_trk;
  assign reversal = have_prev_q && (bus.early != prev_early_q);

  assign ki_ext   = {{(IW-SW){1'b0}}, ki_sel};
  assign ki_s     = bus.early ? ki_ext : -ki_ext;
  assign prop_mag = {1'b0, kp_sel} + (reversal ? {1'b0, bus.kp_boost} : '0);
  assign prop_ext = {{(OW-SW-1){1'b0}}, prop_mag};
  assign prop_s   = bus.early ? prop_ext : -prop_ext;

  sat_add #(.IN_W(IW), .OUT_W(IW)) u_int_add (
    .a_i(int_q), .b_i(ki_s), .sum_o(int_next), .sat_o(int_clamp)
  );

  // Integer part of the new integrator value, arithmetic shift.
  assign int_shr = OW'(int_next >>> FRAC);

  sat_add #(.IN_W(OW), .OUT_W(W)) u_out_add (
    .a_i(int_shr), .b_i(prop_s), .sum_o(dco_next), .sat_o(out_clamp)
  );

  // IW-FRAC == W, so the shifted integrator always fits the output range
  // and the HOLD word needs no clamp.
  assign dco_hold = W'(int_q >>> FRAC);

  // Run-counter arithmetic: compares in CW+1 bits; thresholds of 0 act as 1.
  logic [CW:0]   rev_plus, same_plus, lock_eff, unlock_eff;
  logic [CW-1:0] rev_inc, same_inc;

  assign rev_plus   = {1'b0, rev_cnt_q} + (CW+1)'(1);
  assign same_plus  = {1'b0, same_cnt_q} + (CW+1)'(1);
  assign lock_eff   = (bus.lock_thr   == '0) ? (CW+1)'(1) : {1'b0, bus.lock_thr};
  assign unlock_eff = (bus.unlock_thr == '0) ? (CW+1)'(1) : {1'b0, bus.unlock_thr};
  assign rev_inc    = (&rev_cnt_q)  ? rev_cnt_q  : rev_cnt_q  + CW'(1);
  assign same_inc   = (&same_cnt_q) ? same_cnt_q : same_cnt_q + CW'(1);

  // ---------------- next state ----------------
  always_comb begin
    state_d      = state_q;
    int_d        = int_q;
    dco_d        = dco_q;
    int_sat_d    = 1'b0;
    out_sat_d    = 1'b0;
    rev_cnt_d    = rev_cnt_q;
    same_cnt_d   = same_cnt_q;
    prev_early_d = prev_early_q;
    have_prev_d  = have_prev_q;

    if (bus.freeze) begin
      // Open loop: drop the proportional term, forget decision history.
      state_d     = ST_HOLD;
      dco_d       = dco_hold;
      rev_cnt_d   = '0;
      same_cnt_d  = '0;
      have_prev_d = 1'b0;
    end else if (state_q == ST_HOLD) begin
      state_d = ST_ACQ;  // release cycle; decisions resume next cycle
    end else if (bus.pd_valid) begin
      int_d        = int_next;
      int_sat_d    = int_clamp;
      dco_d        = dco_next;
      out_sat_d    = out_clamp;
      prev_early_d = bus.early;
      have_prev_d  = 1'b1;
      case (state_q)
        ST_ACQ: begin
          if (!reversal) begin
            rev_cnt_d = '0;
          end else if (rev_plus >= lock_eff) begin
            state_d    = ST_TRACK;
            rev_cnt_d  = '0;
            same_cnt_d = '0;
          end else begin
            rev_cnt_d = rev_inc;
          end
        end
        ST_TRACK: begin
          if (reversal) begin
            same_cnt_d = '0;
          end else if (same_plus >= unlock_eff) begin
            state_d    = ST_ACQ;
            rev_cnt_d  = '0;
            same_cnt_d = '0;
          end else begin
            same_cnt_d = same_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: reset is synchronous here, so it sits inside the clocked branch
  // and every state bit is cleared with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ACQ;
      int_q        <= '0;
      dco_q        <= '0;
      int_sat_q    <= 1'b0;
      out_sat_q    <= 1'b0;
      rev_cnt_q    <= '0;
      same_cnt_q   <= '0;
      prev_early_q <= 1'b0;
      have_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      int_q        <= int_d;
      dco_q        <= dco_d;
      int_sat_q    <= int_sat_d;
      out_sat_q    <= out_sat_d;
      rev_cnt_q    <= rev_cnt_d;
      same_cnt_q   <= same_cnt_d;
      prev_early_q <= prev_early_d;
      have_prev_q  <= have_prev_d;
    end
  end

  assign bus.dco_word = dco_q;
  assign bus.int_word = int_q;
  assign bus.int_sat  = int_sat_q;
  assign bus.out_sat  = out_sat_q;
  assign bus.locked   = (state_q == ST_TRACK);
  assign bus.mode     = state_q;

endmodule : adpll_pi_filter_gs

// File: tb/tb_adpll_pi_filter_gs.sv
// -----------------------------------------------------------------------------
// tb_adpll_pi_filter_gs
// Directed scenarios plus randomized decisions/gains. Each driven cycle the
// reference model computes the expected registered outputs and pushes them
// into a queue; a monitor pops one entry after every clock edge and compares.
// -----------------------------------------------------------------------------
module tb_adpll_pi_filter_gs;

  localparam int W    = 8;
  localparam int FRAC = 4;
  localparam int SW   = 6;
  localparam int CW   = 6;
  localparam int IW   = W + FRAC;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  adpll_pi_filter_gs_if #(.W(W), .FRAC(FRAC), .SW(SW), .CW(CW)) bus ();

  adpll_pi_filter_gs #(.W(W), .FRAC(FRAC), .SW(SW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int dco;
    int iw;
    int isat;
    int osat;
    int lck;
    int md;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Gain/threshold settings, applied to the bus together with each decision.
  int g_ki_acq = 0, g_ki_trk = 0, g_kp_acq = 0, g_kp_trk = 0, g_boost = 0;
  int g_lock = 63, g_unlock = 63;

  // ---------------- reference model (spec-level arithmetic) ----------------
  int m_int = 0, m_dco = 0, m_mode = 0, m_rev = 0, m_same = 0;
  int m_isat = 0, m_osat = 0, m_prev = 0, m_have = 0;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // floor(v / 2^FRAC)
  function automatic int floor_div(int v);
    int d = 1 << FRAC;
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  task automatic model_step(input bit r, input bit pd, input bit e, input bit f);
    int s, ki, kp, raw, prop, sum, lt, ut;
    bit rev;
    if (r) begin
      m_int = 0; m_dco = 0; m_isat = 0; m_osat = 0; m_mode = 0;
      m_rev = 0; m_same = 0; m_prev = 0; m_have = 0;
    end else if (f) begin
      m_mode = 2;
      m_dco  = clampi(floor_div(m_int), -(1 << (W-1)), (1 << (W-1)) - 1);
      m_isat = 0; m_osat = 0; m_rev = 0; m_same = 0; m_have = 0;
    end else if (m_mode == 2) begin
      m_mode = 0; m_isat = 0; m_osat = 0;
    end else if (pd) begin
      s    = e ? 1 : -1;
      ki   = (m_mode == 0) ? g_ki_acq : g_ki_trk;
      kp   = (m_mode == 0) ? g_kp_acq : g_kp_trk;
      rev  = m_have && (int'(e) != m_prev);
      raw  = m_int + s * ki;
      m_int  = clampi(raw, -(1 << (IW-1)), (1 << (IW-1)) - 1);
      m_isat = (m_int != raw);
      prop = s * (kp + (rev ? g_boost : 0));
      sum  = floor_div(m_int) + prop;
      m_dco  = clampi(sum, -(1 << (W-1)), (1 << (W-1)) - 1);
      m_osat = (m_dco != sum);
      lt = (g_lock == 0) ? 1 : g_lock;
      ut = (g_unlock == 0) ? 1 : g_unlock;
      if (m_mode == 0) begin
        if (!rev) m_rev = 0;
        else if (m_rev + 1 >= lt) begin m_mode = 1; m_rev = 0; m_same = 0; end
        else m_rev = (m_rev + 1 > 63) ? 63 : m_rev + 1;
      end else begin
        if (rev) m_same = 0;
        else if (m_same + 1 >= ut) begin m_mode = 0; m_rev = 0; m_same = 0; end
        else m_same = (m_same + 1 > 63) ? 63 : m_same + 1;
      end
      m_prev = e; m_have = 1;
    end else begin
      m_isat = 0; m_osat = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit pd, input bit e, input bit f);
    exp_t x;
    @(negedge clk);
    reset          = r;
    bus.pd_valid   = pd;
    bus.early      = e;
    bus.freeze     = f;
    bus.ki_acq     = SW'(g_ki_acq);
    bus.ki_trk     = SW'(g_ki_trk);
    bus.kp_acq     = SW'(g_kp_acq);
    bus.kp_trk     = SW'(g_kp_trk);
    bus.kp_boost   = SW'(g_boost);
    bus.lock_thr   = CW'(g_lock);
    bus.unlock_thr = CW'(g_unlock);
    model_step(r, pd, e, f);
    x.dco = m_dco; x.iw = m_int; x.isat = m_isat; x.osat = m_osat;
    x.lck = (m_mode == 1) ? 1 : 0; x.md = m_mode;
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("dco_word", int'(bus.dco_word), x.dco);
        check("int_word", int'(bus.int_word), x.iw);
        check("int_sat",  int'(bus.int_sat),  x.isat);
        check("out_sat",  int'(bus.out_sat),  x.osat);
        check("locked",   int'(bus.locked),   x.lck);
        check("mode",     int'(bus.mode),     x.md);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit last_e, e, seg;
    reset = 1'b1;
    bus.pd_valid = 1'b0; bus.early = 1'b0; bus.freeze = 1'b0;
    bus.ki_acq = '0; bus.ki_trk = '0; bus.kp_acq = '0; bus.kp_trk = '0;
    bus.kp_boost = '0; bus.lock_thr = '1; bus.unlock_thr = '1;

    // 1: ten early pulses, ki=4 kp=2 -> int 40, dco 4
    g_ki_acq = 4; g_kp_acq = 2; g_boost = 0; g_lock = 63; g_unlock = 63;
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 1, 0);
    drive(0, 0, 0, 0); drive(0, 0, 1, 0);

    // 2: alternating decisions, lock_thr=4, boost=3; then lates to unlock
    drive(1, 0, 0, 0);
    g_boost = 3; g_lock = 4; g_unlock = 3; g_ki_trk = 1; g_kp_trk = 1;
    for (int i = 0; i < 5; i++) drive(0, 1, (i % 2) == 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0);
    drive(0, 1, 1, 0); drive(0, 1, 1, 0);

    // 3: relock, freeze mid-TRACK with pd_valid toggling, then release
    for (int i = 0; i < 6; i++) drive(0, 1, (i % 2) == 1, 0);
    for (int i = 0; i < 4; i++) drive(0, (i % 2) == 0, 1, 1);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 0); drive(0, 1, 0, 0); drive(0, 0, 0, 0);

    // 4: saturation both ways with maximum gains
    drive(1, 0, 0, 0);
    g_ki_acq = 63; g_kp_acq = 63; g_lock = 63;
    for (int i = 0; i < 40; i++) drive(0, 1, 1, 0);
    for (int i = 0; i < 80; i++) drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);

    // 5: reach int_word=-100, then reset together with pd_valid
    drive(1, 0, 0, 0);
    g_ki_acq = 4; g_kp_acq = 2;
    for (int i = 0; i < 25; i++) drive(0, 1, 0, 0);
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);

    // 6: randomized decisions, gains, thresholds, freezes and resets
    last_e = 1'b0; seg = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        g_ki_acq = $urandom_range(0, 63); g_ki_trk = $urandom_range(0, 15);
        g_kp_acq = $urandom_range(0, 63); g_kp_trk = $urandom_range(0, 15);
        g_boost  = $urandom_range(0, 63);
        g_lock   = $urandom_range(0, 5);  g_unlock = $urandom_range(0, 5);
        seg      = $urandom_range(0, 1) == 1;
      end
      // seg=1 favours reversals, seg=0 favours repeated decisions
      if ($urandom_range(0, 9) < 8) e = seg ? ~last_e : last_e;
      else e = $urandom_range(0, 1) == 1;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, e,
            $urandom_range(0, 49) == 0);
      if (bus.pd_valid) last_e = e;
    end

    // drain: every pushed expectation must be consumed by the monitor
    drive(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_adpll_pi_filter_gs
